// File: rtl/hex_rx_pkg.sv
// hex_rx_pkg: shared types and default constants for the hex receive display path
package hex_rx_pkg;
  typedef enum logic {IDLE, ACTIVE} act_state_t;
  typedef logic [3:0] nibble_t;
  localparam int DEF_NUM_BYTES = 3;
  localparam int DEF_HOLD_CYCLES = 25_000_000;
endpackage

// File: rtl/hex_rx_buffer_activity_stretch.sv
// activity_stretch: holds active high for HOLD_CYCLES cycles after the last trig, retriggerable
module activity_stretch import hex_rx_pkg::*; #(
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic trig,
  output logic active
);
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);
  act_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    if (trig) begin
      state_n = ACTIVE;
      cnt_n = RELOAD;
    end else if (state == ACTIVE) begin
      state_n = (cnt == '0) ? IDLE : ACTIVE;
      cnt_n = (cnt == '0) ? cnt : cnt - 1'b1;
    end
  end
  assign active = (state == ACTIVE);
endmodule

// File: rtl/hex_rx_buffer.sv
// hex_rx_buffer: byte history as hex nibbles for the 7-seg decoders, byte counter and activity LED.
// Define RX_ERR_EN to drop errored bytes and flag them on err_sticky.
module hex_rx_buffer import hex_rx_pkg::*; #(
  parameter int NUM_BYTES = DEF_NUM_BYTES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  input  logic                   rx_err,
  input  logic                   clear,
  input  logic                   freeze,
  output logic [8*NUM_BYTES-1:0] hex_digits,
  output logic [2*NUM_BYTES-1:0] digit_valid,
  output logic [7:0]             byte_count,
  output logic                   activity,
  output logic                   err_sticky
);
  logic trig, acc;
  assign trig = rx_valid & ~clear;
`ifdef RX_ERR_EN
  assign acc = trig & ~rx_err;
  always_ff @(posedge clk) begin
    if (rst || clear) err_sticky <= 1'b0;
    else if (trig && rx_err) err_sticky <= 1'b1;
  end
`else
  assign acc = trig;
  assign err_sticky = rx_err & 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hex_digits <= '0;
      digit_valid <= '0;
      byte_count <= '0;
    end else if (acc) begin
      byte_count <= byte_count + 8'd1;
      if (!freeze) begin
        hex_digits <= (hex_digits << 8) | (8*NUM_BYTES)'(rx_data);
        digit_valid <= (digit_valid << 2) | (2*NUM_BYTES)'(2'b11);
      end
    end
  end
  activity_stretch #(.HOLD_CYCLES(HOLD_CYCLES)) u_act (
    .clk(clk),
    .rst(rst),
    .trig(trig),
    .active(activity)
  );
endmodule

// File: tb/tb_hex_rx_buffer.sv
// tb_hex_rx_buffer: randomized and directed checks of hex_rx_buffer against a byte-history model
module tb_hex_rx_buffer;
  localparam int NB = 3;
  localparam int HOLD = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] rx_data = '0;
  logic rx_valid = 1'b0;
  logic rx_err = 1'b0;
  logic clear = 1'b0;
  logic freeze = 1'b0;
  logic [8*NB-1:0] hex_digits;
  logic [2*NB-1:0] digit_valid;
  logic [7:0] byte_count;
  logic activity;
  logic err_sticky;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  hex_rx_buffer #(.NUM_BYTES(NB), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_err(rx_err),
    .clear(clear), .freeze(freeze), .hex_digits(hex_digits), .digit_valid(digit_valid),
    .byte_count(byte_count), .activity(activity), .err_sticky(err_sticky)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // Reference model: newest-first list of stored bytes, how many are valid,
  // and cycles elapsed since the last activity trigger.
  byte unsigned m_hist[NB];
  int m_nvalid = 0;
  int m_count = 0;
  bit m_err = 0;
  int m_since = HOLD + 1;
  bit err_en;
  initial begin
`ifdef RX_ERR_EN
    err_en = 1;
`else
    err_en = 0;
`endif
  end
  always @(posedge clk) begin
    logic [8*NB-1:0] exp_hex;
    bit t, a;
    t = rx_valid && !clear;
    a = t && !(err_en && rx_err);
    if (rst) begin
      foreach (m_hist[i]) m_hist[i] = 0;
      m_nvalid = 0; m_count = 0; m_err = 0; m_since = HOLD + 1;
    end else begin
      if (clear) begin
        foreach (m_hist[i]) m_hist[i] = 0;
        m_nvalid = 0; m_count = 0; m_err = 0;
      end else if (a) begin
        m_count = (m_count + 1) % 256;
        if (!freeze) begin
          for (int i = NB - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
          m_hist[0] = rx_data;
          if (m_nvalid < NB) m_nvalid++;
        end
      end
      if (err_en && t && rx_err) m_err = 1;
      if (t) m_since = 1;
      else if (m_since <= HOLD) m_since++;
    end
    exp_hex = '0;
    for (int i = 0; i < NB; i++) exp_hex[8*i +: 8] = m_hist[i];
    #1;
    check("hex_digits", 32'(hex_digits), 32'(exp_hex));
    check("digit_valid", 32'(digit_valid), (32'd1 << (2 * m_nvalid)) - 1);
    check("byte_count", 32'(byte_count), 32'(m_count));
    check("activity", 32'(activity), 32'(m_since >= 1 && m_since <= HOLD));
    check("err_sticky", 32'(err_sticky), 32'(m_err));
  end
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic sendb(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
  endtask
  task automatic pulse_clear;
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask
  initial begin
    tick();
    tick();
    rst = 1'b0;
    check("reset hex", 32'(hex_digits), 0);
    check("reset dv", 32'(digit_valid), 0);
    check("reset count", 32'(byte_count), 0);
    check("reset activity", 32'(activity), 0);
    sendb(8'h3A);
    sendb(8'h7F);
    sendb(8'hC5);
    check("three hex", 32'(hex_digits), 32'h3A7FC5);
    check("three dv", 32'(digit_valid), 32'h3F);
    check("three count", 32'(byte_count), 3);
    pulse_clear();
    sendb(8'h12);
    check("one dv", 32'(digit_valid), 32'b000011);
    check("one hex", 32'(hex_digits), 32'h000012);
    freeze = 1'b1;
    sendb(8'hAA);
    check("freeze hex", 32'(hex_digits), 32'h000012);
    check("freeze count", 32'(byte_count), 2);
    freeze = 1'b0;
    sendb(8'h55);
    check("unfreeze hex", 32'(hex_digits), 32'h001255);
    check("unfreeze dv", 32'(digit_valid), 32'h0F);
    repeat (HOLD + 2) tick();
    check("idle before hold", 32'(activity), 0);
    sendb(8'h01);
    for (int c = 1; c <= HOLD; c++) begin
      check("hold high", 32'(activity), 1);
      tick();
    end
    check("hold low", 32'(activity), 0);
    sendb(8'h02);
    tick();
    tick();
    sendb(8'h03);
    for (int c = 4; c <= 7; c++) begin
      check("retrigger high", 32'(activity), 1);
      tick();
    end
    check("retrigger low", 32'(activity), 0);
    pulse_clear();
    for (int i = 0; i < 256; i++) begin
      rx_data = 8'($urandom);
      rx_valid = 1'b1;
      tick();
    end
    rx_valid = 1'b0;
    check("wrap count", 32'(byte_count), 0);
    rx_data = 8'h99;
    rx_valid = 1'b1;
    clear = 1'b1;
    tick();
    rx_valid = 1'b0;
    clear = 1'b0;
    check("clear hex", 32'(hex_digits), 0);
    check("clear dv", 32'(digit_valid), 0);
    check("clear count", 32'(byte_count), 0);
`ifdef RX_ERR_EN
    sendb(8'h21);
    rx_err = 1'b1;
    sendb(8'hEE);
    rx_err = 1'b0;
    check("err hex", 32'(hex_digits), 32'h000021);
    check("err count", 32'(byte_count), 1);
    check("err sticky", 32'(err_sticky), 1);
    check("err activity", 32'(activity), 1);
    pulse_clear();
    check("err cleared", 32'(err_sticky), 0);
`endif
    for (int i = 0; i < 3000; i++) begin
      rx_data = 8'($urandom);
      rx_valid = ($urandom_range(0, 2) != 0);
      rx_err = ($urandom_range(0, 5) == 0);
      clear = ($urandom_range(0, 60) == 0);
      freeze = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 300) == 0);
      if ($urandom_range(0, 40) == 0) begin
        rx_valid = 1'b0;
        repeat (HOLD + 1) tick();
      end
      tick();
    end
    rx_valid = 1'b0;
    rst = 1'b0;
    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
